// File: rtl/memory_arbiter_rr.sv
// memory_arbiter_rr
// -----------------
// N-channel arbiter between cache-side requesters and a single RAM port.
// Arbitration is fixed-priority (lowest index wins) or round-robin. A grant
// can be held across several consecutive accesses through req_lock. The
// burst is capped at MAX_BURST accesses, after which the owner must
// re-arbitrate. A RAM ERROR response is reported to the owning channel.
//
// Ports:
//   CLK, nrst        clock, asynchronous active-low reset
//   req_ren/req_wen  per-channel read / write request
//   req_lock         per-channel: keep the grant after the current access
//   req_addr         per-channel address, channel i at [i*AW +: AW]
//   req_store        per-channel write data, channel i at [i*DW +: DW]
//   req_wait         per-channel: request pending and not completing now
//   req_err          per-channel: the completion this cycle carried ERROR
//   req_load         read data broadcast, valid for the completing channel
//   grant_valid      a channel owns the RAM port
//   grant_id         owning channel
//   ramaddr, ramstore, ramREN, ramWEN   driven to RAM from the owner
//   ramload, ramstate                   from RAM (0 FREE,1 BUSY,2 ACCESS,3 ERROR)

module memory_arbiter_rr #(
    parameter int NCH       = 3,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RR_MODE   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                     CLK,
    input  logic                     nrst,
    input  logic [NCH-1:0]           req_ren,
    input  logic [NCH-1:0]           req_wen,
    input  logic [NCH-1:0]           req_lock,
    input  logic [NCH*AW-1:0]        req_addr,
    input  logic [NCH*DW-1:0]        req_store,
    output logic [NCH-1:0]           req_wait,
    output logic [NCH-1:0]           req_err,
    output logic [DW-1:0]            req_load,
    output logic                     grant_valid,
    output logic [$clog2(NCH)-1:0]   grant_id,
    output logic [AW-1:0]            ramaddr,
    output logic [DW-1:0]            ramstore,
    output logic                     ramREN,
    output logic                     ramWEN,
    input  logic [DW-1:0]            ramload,
    input  logic [1:0]               ramstate
);

    localparam int IW = $clog2(NCH);
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [IW:0]   NCH_W   = (IW+1)'(NCH);
    localparam logic [CW-1:0] MAXB_W  = CW'(MAX_BURST);
    localparam logic [IW-1:0] PTR_RST = IW'(NCH - 1);

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [IW-1:0]   grant_id_r, grant_id_s;
    logic            grant_valid_r, grant_valid_s;
    logic [IW-1:0]   ptr_r, ptr_s;
    logic [CW-1:0]   cnt_r, cnt_s;

    logic [NCH-1:0]  req_any_s;
    logic [NCH-1:0]  done_s;
    logic            done_any_s;
    logic            any_req_s;
    logic [IW-1:0]   winner_s;
    logic            found_s;
    logic [IW:0]     cand_s;
    logic [IW:0]     sum_s;

    logic            owner_ren_s;
    logic            owner_wen_s;
    logic            owner_lock_s;
    logic            owner_act_s;
    logic [AW-1:0]   owner_addr_s;
    logic [DW-1:0]   owner_store_s;
    logic            ram_ans_s;

    assign req_any_s = req_ren | req_wen;
    assign any_req_s = |req_any_s;

    // RAM has answered this cycle (data or error); BUSY and FREE both mean hold.
    assign ram_ans_s = (ramstate == RS_ACCESS) || (ramstate == RS_ERROR);

    // Pick the next owner: round-robin scan from ptr+1, or lowest index.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        cand_s   = '0;
        sum_s    = '0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NCH; k++) begin
                sum_s  = {1'b0, ptr_r} + (IW+1)'(k);
                cand_s = (sum_s >= NCH_W) ? (sum_s - NCH_W) : sum_s;
                if (!found_s && req_any_s[cand_s[IW-1:0]]) begin
                    found_s  = 1'b1;
                    winner_s = cand_s[IW-1:0];
                end else begin
                    winner_s = winner_s;
                end
            end
        end else begin
            // Scan downwards so the lowest requesting index is the last write.
            for (int i = NCH - 1; i >= 0; i--) begin
                if (req_any_s[i]) begin
                    winner_s = IW'(i);
                end else begin
                    winner_s = winner_s;
                end
            end
        end
    end

    // Select the owning channel's request signals.
    always_comb begin
        owner_ren_s   = 1'b0;
        owner_wen_s   = 1'b0;
        owner_lock_s  = 1'b0;
        owner_addr_s  = '0;
        owner_store_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_id_r == IW'(i)) begin
                owner_ren_s   = req_ren[i];
                owner_wen_s   = req_wen[i];
                owner_lock_s  = req_lock[i];
                owner_addr_s  = req_addr[i*AW +: AW];
                owner_store_s = req_store[i*DW +: DW];
            end else begin
                owner_ren_s = owner_ren_s;
            end
        end
    end

    assign owner_act_s = owner_ren_s | owner_wen_s;

    // Completion strobe: only the owner, only while it still requests.
    always_comb begin
        done_s = '0;
        for (int i = 0; i < NCH; i++) begin
            done_s[i] = (state_r == ST_GRANTED) && (grant_id_r == IW'(i)) &&
                        owner_act_s && ram_ans_s;
        end
    end

    assign done_any_s = |done_s;

    assign req_wait    = req_any_s & ~done_s;
    assign req_err     = done_s & {NCH{ramstate == RS_ERROR}};
    assign req_load    = done_any_s ? ramload : '0;
    assign grant_valid = grant_valid_r;
    assign grant_id    = grant_id_r;

    // Drive the RAM port from the owner; a write wins over a simultaneous read.
    always_comb begin
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        if ((state_r == ST_GRANTED) && owner_act_s) begin
            ramaddr  = owner_addr_s;
            ramstore = owner_store_s;
            ramWEN   = owner_wen_s;
            ramREN   = owner_ren_s & ~owner_wen_s;
        end else begin
            ramREN   = 1'b0;
        end
    end

    // Next-state logic for grant ownership, burst count and RR pointer.
    always_comb begin
        state_s       = state_r;
        grant_id_s    = grant_id_r;
        grant_valid_s = grant_valid_r;
        ptr_s         = ptr_r;
        cnt_s         = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_id_s    = winner_s;
                    grant_valid_s = 1'b1;
                    state_s       = ST_GRANTED;
                end else begin
                    state_s       = ST_IDLE;
                end
            end
            ST_GRANTED: begin
                if (!owner_act_s) begin
                    // Abort: owner walked away; pointer is left untouched.
                    grant_valid_s = 1'b0;
                    cnt_s         = '0;
                    state_s       = ST_IDLE;
                end else if (done_any_s) begin
                    if (owner_lock_s && ((cnt_r + CW'(1)) < MAXB_W)) begin
                        cnt_s   = cnt_r + CW'(1);
                        state_s = ST_GRANTED;
                    end else begin
                        grant_valid_s = 1'b0;
                        cnt_s         = '0;
                        ptr_s         = grant_id_r;
                        state_s       = ST_IDLE;
                    end
                end else begin
                    state_s = ST_GRANTED;
                end
            end
            default: begin
                state_s       = ST_IDLE;
                grant_valid_s = 1'b0;
                cnt_s         = '0;
            end
        endcase
    end

    // State registers; reset leaves the pointer at NCH-1 so RR starts at 0.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state_r       <= ST_IDLE;
            grant_id_r    <= '0;
            grant_valid_r <= 1'b0;
            ptr_r         <= PTR_RST;
            cnt_r         <= '0;
        end else begin
            state_r       <= state_s;
            grant_id_r    <= grant_id_s;
            grant_valid_r <= grant_valid_s;
            ptr_r         <= ptr_s;
            cnt_r         <= cnt_s;
        end
    end

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Directed bench for memory_arbiter_rr: a round-robin instance (MAX_BURST=4)
// and a fixed-priority instance share the same request and RAM stimulus.
module tb_memory_arbiter_rr;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic               CLK;
    logic               nrst;
    logic [NCH-1:0]     req_ren;
    logic [NCH-1:0]     req_wen;
    logic [NCH-1:0]     req_lock;
    logic [NCH*AW-1:0]  req_addr;
    logic [NCH*DW-1:0]  req_store;
    logic [DW-1:0]      ramload;
    logic [1:0]         ramstate;

    logic [NCH-1:0]     req_wait,  f_req_wait;
    logic [NCH-1:0]     req_err,   f_req_err;
    logic [DW-1:0]      req_load,  f_req_load;
    logic               grant_valid, f_grant_valid;
    logic [1:0]         grant_id,  f_grant_id;
    logic [AW-1:0]      ramaddr,   f_ramaddr;
    logic [DW-1:0]      ramstore,  f_ramstore;
    logic               ramREN,    f_ramREN;
    logic               ramWEN,    f_ramWEN;

    int errors = 0;
    int checks = 0;
    int rr_exp [6] = '{0, 1, 2, 0, 1, 2};

    memory_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW), .RR_MODE(1), .MAX_BURST(4)) u_rr (
        .CLK(CLK), .nrst(nrst),
        .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
        .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_err(req_err), .req_load(req_load),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramload(ramload), .ramstate(ramstate)
    );

    memory_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW), .RR_MODE(0), .MAX_BURST(4)) u_fix (
        .CLK(CLK), .nrst(nrst),
        .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
        .req_addr(req_addr), .req_store(req_store),
        .req_wait(f_req_wait), .req_err(f_req_err), .req_load(f_req_load),
        .grant_valid(f_grant_valid), .grant_id(f_grant_id),
        .ramaddr(f_ramaddr), .ramstore(f_ramstore), .ramREN(f_ramREN), .ramWEN(f_ramWEN),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Move to the falling edge of the current cycle (sample point).
    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic clr_inputs();
        req_ren   = '0;
        req_wen   = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_store = '0;
        ramload   = '0;
        ramstate  = 2'd0;
    endtask

    task automatic do_reset();
        clr_inputs();
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    initial begin
        clr_inputs();
        nrst = 1'b0;
        #2;
        tick();
        mid();
        // Reset state
        chk("rst_gvalid", 64'(grant_valid), 64'(0));
        chk("rst_gid",    64'(grant_id),    64'(0));
        chk("rst_ren",    64'(ramREN),      64'(0));
        chk("rst_wen",    64'(ramWEN),      64'(0));
        chk("rst_addr",   64'(ramaddr),     64'(0));
        tick();
        nrst = 1'b1;

        // Single read on ch1
        req_ren[1] = 1'b1;
        req_addr[1*AW +: AW] = 32'h0000_0040;
        ramstate = 2'd2;
        ramload  = 32'hDEAD_BEEF;
        mid();
        chk("rd_c0_wait",   64'(req_wait),    64'(3'b010));
        chk("rd_c0_gvalid", 64'(grant_valid), 64'(0));
        chk("rd_c0_ren",    64'(ramREN),      64'(0));
        tick();
        mid();
        chk("rd_c1_gvalid", 64'(grant_valid), 64'(1));
        chk("rd_c1_gid",    64'(grant_id),    64'(1));
        chk("rd_c1_ren",    64'(ramREN),      64'(1));
        chk("rd_c1_addr",   64'(ramaddr),     64'(32'h40));
        chk("rd_c1_wait",   64'(req_wait),    64'(3'b000));
        chk("rd_c1_load",   64'(req_load),    64'(32'hDEAD_BEEF));
        chk("rd_c1_err",    64'(req_err),     64'(3'b000));
        tick();
        req_ren = '0;
        mid();
        chk("rd_c2_gvalid", 64'(grant_valid), 64'(0));

        // Round-robin fairness versus fixed priority
        do_reset();
        req_ren  = 3'b111;
        ramstate = 2'd2;
        for (int k = 0; k < 6; k++) begin
            tick();
            mid();
            chk("rr_gvalid",  64'(grant_valid), 64'(1));
            chk("rr_gid",     64'(grant_id),    64'(rr_exp[k]));
            chk("fix_gid",    64'(f_grant_id),  64'(0));
            tick();
            mid();
            chk("rr_idle",    64'(grant_valid), 64'(0));
        end

        // Locked burst on ch0 capped at 4, ch2 waiting
        do_reset();
        req_ren  = 3'b101;
        req_lock = 3'b001;
        req_addr[0*AW +: AW] = 32'h0000_0100;
        req_addr[2*AW +: AW] = 32'h0000_0300;
        ramstate = 2'd2;
        for (int b = 0; b < 4; b++) begin
            tick();
            req_addr[0*AW +: AW] = 32'h0000_0100 + 32'(4 * b);
            mid();
            chk("bst_gvalid", 64'(grant_valid), 64'(1));
            chk("bst_gid",    64'(grant_id),    64'(0));
            chk("bst_addr",   64'(ramaddr),     64'(32'h100 + 32'(4 * b)));
            chk("bst_wait",   64'(req_wait),    64'(3'b100));
        end
        tick();
        mid();
        chk("bst_release", 64'(grant_valid), 64'(0));
        tick();
        mid();
        chk("bst_next_gid",  64'(grant_id),   64'(2));
        chk("bst_next_addr", 64'(ramaddr),    64'(32'h300));
        chk("bst_fix_gid",   64'(f_grant_id), 64'(0));

        // Wait states on a ch2 write (read also asserted: write wins)
        do_reset();
        req_wen[2] = 1'b1;
        req_ren[2] = 1'b1;
        req_addr[2*AW +: AW]  = 32'h0000_0200;
        req_store[2*DW +: DW] = 32'h1234_5678;
        ramstate = 2'd1;
        for (int w = 0; w < 3; w++) begin
            tick();
            mid();
            chk("ws_wen",   64'(ramWEN),   64'(1));
            chk("ws_ren",   64'(ramREN),   64'(0));
            chk("ws_store", 64'(ramstore), 64'(32'h1234_5678));
            chk("ws_wait",  64'(req_wait), 64'(3'b100));
        end
        tick();
        ramstate = 2'd2;
        mid();
        chk("ws_last_wen",   64'(ramWEN),   64'(1));
        chk("ws_last_store", 64'(ramstore), 64'(32'h1234_5678));
        chk("ws_last_wait",  64'(req_wait), 64'(3'b000));

        // RAM error on ch1 read
        do_reset();
        req_ren[1] = 1'b1;
        ramstate   = 2'd3;
        tick();
        mid();
        chk("err_flag",   64'(req_err),     64'(3'b010));
        chk("err_wait",   64'(req_wait),    64'(3'b000));
        chk("err_gvalid", 64'(grant_valid), 64'(1));
        tick();
        req_ren = '0;
        mid();
        chk("err_release", 64'(grant_valid), 64'(0));
        chk("err_clear",   64'(req_err),     64'(3'b000));

        // Abort: ch0 drops its read during BUSY
        do_reset();
        req_ren[0] = 1'b1;
        ramstate   = 2'd1;
        tick();
        mid();
        chk("ab_ren_on", 64'(ramREN),   64'(1));
        chk("ab_wait",   64'(req_wait), 64'(3'b001));
        tick();
        req_ren = '0;
        mid();
        chk("ab_ren_off", 64'(ramREN),      64'(0));
        chk("ab_held",    64'(grant_valid), 64'(1));
        tick();
        req_ren  = 3'b011;
        ramstate = 2'd2;
        mid();
        chk("ab_idle", 64'(grant_valid), 64'(0));
        tick();
        mid();
        chk("ab_ptr_gid", 64'(grant_id), 64'(0));

        // Asynchronous reset during a BUSY locked burst
        do_reset();
        req_ren[1]  = 1'b1;
        req_lock[1] = 1'b1;
        ramstate    = 2'd1;
        tick();
        mid();
        chk("ar_pre_gvalid", 64'(grant_valid), 64'(1));
        chk("ar_pre_ren",    64'(ramREN),      64'(1));
        tick();
        #2;
        nrst = 1'b0;
        #1;
        chk("ar_gvalid", 64'(grant_valid), 64'(0));
        chk("ar_ren",    64'(ramREN),      64'(0));
        chk("ar_wen",    64'(ramWEN),      64'(0));
        chk("ar_wait",   64'(req_wait),    64'(3'b010));
        tick();
        req_ren[2] = 1'b1;
        nrst = 1'b1;
        tick();
        mid();
        chk("ar_first_gid",  64'(grant_id),    64'(1));
        chk("ar_first_gval", 64'(grant_valid), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
